// File: rtl/vga_pkg.sv
// Shared VGA definitions: framebuffer grant encoding and default 640x480 geometry.
package vga_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_SCAN = 2'd1,
    GNT_WR   = 2'd2
  } gnt_e;

  localparam int unsigned H_ACTIVE  = 640;
  localparam int unsigned V_ACTIVE  = 480;
  localparam int unsigned FB_WORDS  = H_ACTIVE * V_ACTIVE;
  localparam int unsigned FB_ADDR_W = $clog2(FB_WORDS);
  localparam int unsigned PIX_W     = 12;

endpackage

// File: rtl/vga_rd_tag_pipe.sv
// Read-return delay line: tags each scan request and captures RAM data when it arrives.
module vga_rd_tag_pipe #(
  parameter int unsigned LAT    = 1,
  parameter int unsigned DATA_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_rdata
);

  // r_tag[k] is set in the cycle k after the command was issued; stage LAT meets mem_rdata.
  logic [LAT:0]        r_tag;
  logic                r_rvalid;
  logic [DATA_W-1:0]   r_rdata;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tag    <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_tag    <= {r_tag[LAT-1:0], i_req};
      r_rvalid <= r_tag[LAT];
      if (r_tag[LAT]) begin
        r_rdata <= i_rdata;
      end
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads always win, writes use valid/ready and
// may be restricted to vertical blanking; stalled write cycles are counted.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W         = FB_ADDR_W,
  parameter int unsigned DATA_W         = PIX_W,
  parameter int unsigned MEM_LAT        = 1,
  parameter bit          WR_VBLANK_ONLY = 1'b0,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_vblank,
  input  logic              i_scan_req,
  input  logic [ADDR_W-1:0] i_scan_addr,
  output logic              o_scan_rvalid,
  output logic [DATA_W-1:0] o_scan_rdata,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_stat_clr,
  output logic [CNT_W-1:0]  o_wr_stall_cnt
);

  gnt_e              w_gnt;
  logic              w_wr_window;
  logic              w_stall;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [CNT_W-1:0]  r_stall_cnt;

  assign w_wr_window = !WR_VBLANK_ONLY || i_vblank;
  assign o_wr_ready  = !i_scan_req && w_wr_window;
  assign w_stall     = i_wr_valid && !o_wr_ready;

  always_comb begin
    if (i_scan_req) begin
      w_gnt = GNT_SCAN;
    end else if (i_wr_valid && w_wr_window) begin
      w_gnt = GNT_WR;
    end else begin
      w_gnt = GNT_NONE;
    end
  end

  // Idle cycles keep address/data so the RAM port only toggles en/we.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      unique case (w_gnt)
        GNT_SCAN: begin
          r_mem_en   <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_addr <= i_scan_addr;
        end
        GNT_WR: begin
          r_mem_en    <= 1'b1;
          r_mem_we    <= 1'b1;
          r_mem_addr  <= i_wr_addr;
          r_mem_wdata <= i_wr_data;
        end
        default: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
    end else if (i_stat_clr) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  vga_rd_tag_pipe #(
    .LAT    (MEM_LAT),
    .DATA_W (DATA_W)
  ) u_tag_pipe (
    .i_clk    (i_clk),
    .i_rst    (i_reset),
    .i_req    (i_scan_req),
    .i_rdata  (i_mem_rdata),
    .o_rvalid (o_scan_rvalid),
    .o_rdata  (o_scan_rdata)
  );

  assign o_mem_en       = r_mem_en;
  assign o_mem_we       = r_mem_we;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_wr_stall_cnt = r_stall_cnt;

endmodule
